// File: rtl/chroma_modulator.sv
// Composite video (CVBS) back end: subcarrier NCO, sine/cosine lookup,
// quadrature chroma modulation with PAL V-switch, burst insertion and
// sync/blank level generation. One sample per clock, fixed 4-clock latency.
module chroma_modulator #(
   parameter logic [31:0] PHASE_INC   = 32'd396713490,
   parameter bit          PAL         = 1'b1,
   parameter logic [7:0]  BLANK_LEVEL = 8'd64,
   parameter logic [7:0]  LUMA_GAIN   = 8'd160,
   parameter logic [6:0]  BURST_AMP   = 7'd20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] y,
   input  logic [7:0] cb,
   input  logic [7:0] cr,
   input  logic       sync,
   input  logic       burst,
   input  logic       blank,
   input  logic       line_start,
   input  logic       phase_rst,
   output logic [7:0] cvbs
);

   // round(127*sin(2*pi*i/256)) for the first quarter wave, i = 0..64
   localparam logic [6:0] QSIN [0:64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
      7'd127
   };

   // Full-wave sine from the quarter table: mirror in quadrants 1/3, negate in 2/3.
   function automatic logic [7:0] sine8(input logic [7:0] a);
      logic [6:0] idx;
      logic [7:0] mag;
      idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
      mag = {1'b0, QSIN[idx]};
      return a[7] ? (8'd0 - mag) : mag;
   endfunction

   // Saturate an 11-bit signed level to the 8-bit DAC range.
   function automatic logic [7:0] clamp8(input logic [10:0] s);
      if (s[10])
         return 8'd0;
      else if (s[9:8] != 2'b00)
         return 8'd255;
      else
         return s[7:0];
   endfunction

   logic [31:0] phase;
   logic        vsw;

   logic       s1_vld, s1_sync, s1_burst, s1_blank, s1_vsw;
   logic [7:0] s1_addr, s1_y, s1_cb, s1_cr;

   logic       s2_vld, s2_sync, s2_burst, s2_blank;
   logic [7:0] s2_sin, s2_cos, s2_cb, s2_luma;
   logic [8:0] s2_crv;

   logic        s3_vld, s3_sync, s3_burst, s3_blank;
   logic [15:0] s3_u;
   logic [16:0] s3_v;
   logic [7:0]  s3_luma;

   logic       s4_vld, s4_sync, s4_burst, s4_blank;
   logic [9:0] s4_chroma;
   logic [7:0] s4_luma;

   logic [7:0]         cb_e;
   logic [8:0]         cr_e, cr_v;
   logic [15:0]        luma_prod;
   logic signed [17:0] uv_sum;
   logic [10:0]        sum_burst, sum_act;

   // NCO accumulator and PAL line-alternation flag
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= 32'd0;
         vsw   <= 1'b0;
      end else begin
         phase <= phase_rst ? 32'd0 : phase + PHASE_INC;
         if (PAL && line_start)
            vsw <= ~vsw;
      end
   end

   // Stage 1: capture pixel, controls, pre-update phase and V-switch
   always_ff @(posedge clk) begin
      if (rst) begin
         {s1_vld, s1_sync, s1_burst, s1_blank, s1_vsw} <= '0;
         {s1_addr, s1_y, s1_cb, s1_cr}                 <= '0;
      end else begin
         {s1_vld, s1_sync, s1_burst, s1_blank, s1_vsw} <= {1'b1, sync, burst, blank, vsw};
         {s1_addr, s1_y, s1_cb, s1_cr}                 <= {phase[31:24], y, cb, cr};
      end
   end

   // Effective chroma operands: burst substitutes fixed amplitudes, V-switch negates V
   always_comb begin
      cb_e      = s1_burst ? (8'd0 - {1'b0, BURST_AMP}) : s1_cb;
      cr_e      = s1_burst ? (PAL ? {2'b00, BURST_AMP} : 9'd0) : {s1_cr[7], s1_cr};
      cr_v      = s1_vsw ? (9'd0 - cr_e) : cr_e;
      luma_prod = {8'd0, s1_y} * {8'd0, LUMA_GAIN};
   end

   // Stage 2: sine/cosine lookup and luma scaling
   always_ff @(posedge clk) begin
      if (rst) begin
         {s2_vld, s2_sync, s2_burst, s2_blank} <= '0;
         {s2_sin, s2_cos, s2_cb, s2_luma}      <= '0;
         s2_crv                                <= '0;
      end else begin
         {s2_vld, s2_sync, s2_burst, s2_blank} <= {s1_vld, s1_sync, s1_burst, s1_blank};
         s2_sin  <= sine8(s1_addr);
         s2_cos  <= sine8(s1_addr + 8'd64);
         s2_cb   <= cb_e;
         s2_crv  <= cr_v;
         s2_luma <= 8'(luma_prod >> 8);
      end
   end

   // Stage 3: quadrature products (operands sign-extended to the product width)
   always_ff @(posedge clk) begin
      if (rst) begin
         {s3_vld, s3_sync, s3_burst, s3_blank} <= '0;
         s3_u    <= '0;
         s3_v    <= '0;
         s3_luma <= '0;
      end else begin
         {s3_vld, s3_sync, s3_burst, s3_blank} <= {s2_vld, s2_sync, s2_burst, s2_blank};
         s3_u    <= {{8{s2_cb[7]}}, s2_cb} * {{8{s2_sin[7]}}, s2_sin};
         s3_v    <= {{8{s2_crv[8]}}, s2_crv} * {{9{s2_cos[7]}}, s2_cos};
         s3_luma <= s2_luma;
      end
   end

   always_comb begin
      uv_sum = {{2{s3_u[15]}}, s3_u} + {s3_v[16], s3_v};
   end

   // Stage 4: chroma sum, floor-scaled back to signed 10 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         {s4_vld, s4_sync, s4_burst, s4_blank} <= '0;
         s4_chroma <= '0;
         s4_luma   <= '0;
      end else begin
         {s4_vld, s4_sync, s4_burst, s4_blank} <= {s3_vld, s3_sync, s3_burst, s3_blank};
         s4_chroma <= 10'(uv_sum >>> 8);
         s4_luma   <= s3_luma;
      end
   end

   always_comb begin
      sum_burst = {3'b000, BLANK_LEVEL} + {s4_chroma[9], s4_chroma};
      sum_act   = sum_burst + {3'b000, s4_luma};
   end

   // Output: level select by priority, then clamp; stays 0 until real samples arrive
   always_ff @(posedge clk) begin
      if (rst)
         cvbs <= 8'd0;
      else if (!s4_vld || s4_sync)
         cvbs <= 8'd0;
      else if (s4_burst)
         cvbs <= clamp8(sum_burst);
      else if (s4_blank)
         cvbs <= BLANK_LEVEL;
      else
         cvbs <= clamp8(sum_act);
   end

endmodule

// File: tb/tb_chroma_modulator.sv
// Scoreboard bench for chroma_modulator. Three instances share stimulus:
// a = PAL defaults, b = PAL with BLANK_LEVEL 32, n = NTSC. All use a
// quarter-cycle NCO step so LUT addresses walk 0, 64, 128, 192.
module tb_chroma_modulator;

   logic       clk;
   logic       rst, sync, burst, blank, line_start, phase_rst;
   logic [7:0] y, cb, cr;
   logic [7:0] cvbs_a, cvbs_b, cvbs_n;

   typedef struct {
      int         due;
      int         vec;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [7:0] en;
      logic [2:0] mask;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   edge_cnt = 0;
   int   vec_id   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_RST   = 6'b100000;
   localparam logic [5:0] C_SYNC  = 6'b010000;
   localparam logic [5:0] C_BURST = 6'b001000;
   localparam logic [5:0] C_BLANK = 6'b000100;
   localparam logic [5:0] C_LS    = 6'b000010;
   localparam logic [5:0] C_PR    = 6'b000001;

   localparam logic [2:0] M_NONE = 3'b000;
   localparam logic [2:0] M_ALL  = 3'b111;

   chroma_modulator #(.PHASE_INC(32'h4000_0000), .PAL(1'b1), .BLANK_LEVEL(8'd64)) dut_a (
      .clk(clk), .rst(rst), .y(y), .cb(cb), .cr(cr), .sync(sync), .burst(burst),
      .blank(blank), .line_start(line_start), .phase_rst(phase_rst), .cvbs(cvbs_a));

   chroma_modulator #(.PHASE_INC(32'h4000_0000), .PAL(1'b1), .BLANK_LEVEL(8'd32)) dut_b (
      .clk(clk), .rst(rst), .y(y), .cb(cb), .cr(cr), .sync(sync), .burst(burst),
      .blank(blank), .line_start(line_start), .phase_rst(phase_rst), .cvbs(cvbs_b));

   chroma_modulator #(.PHASE_INC(32'h4000_0000), .PAL(1'b0), .BLANK_LEVEL(8'd64)) dut_n (
      .clk(clk), .rst(rst), .y(y), .cb(cb), .cr(cr), .sync(sync), .burst(burst),
      .blank(blank), .line_start(line_start), .phase_rst(phase_rst), .cvbs(cvbs_n));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input int vec, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL cvbs_%s vec %0d: got %0d expected %0d", tag, vec, act, exp);
   endtask

   // Monitor: compare every output whose sample has reached the end of the pipeline
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         e = sb.pop_front();
         if (e.mask[0]) check("a", e.vec, cvbs_a, e.ea);
         if (e.mask[1]) check("b", e.vec, cvbs_b, e.eb);
         if (e.mask[2]) check("n", e.vec, cvbs_n, e.en);
      end
   end

   // Drive one sample (sampled at the next edge) and book its expected output 4 edges later
   task automatic step(input logic [7:0] vy, input logic [7:0] vcb, input logic [7:0] vcr,
                       input logic [5:0] ctl, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] en, input logic [2:0] mask);
      exp_t t;
      {rst, sync, burst, blank, line_start, phase_rst} = ctl;
      y  = vy;
      cb = vcb;
      cr = vcr;
      t.due  = edge_cnt + 5;
      t.vec  = vec_id;
      t.ea   = ea;
      t.eb   = eb;
      t.en   = en;
      t.mask = mask;
      sb.push_back(t);
      vec_id++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      {rst, sync, burst, blank, line_start, phase_rst} = C_NONE;
      y = 8'd0; cb = 8'd0; cr = 8'd0;

      // reset, then pipeline flushes with zeros to the blanking level
      step(8'd0, 8'd0, 8'd0, C_RST, 8'd0, 8'd0, 8'd0, M_ALL);
      step(8'd0, 8'd0, 8'd0, C_RST, 8'd0, 8'd0, 8'd0, M_ALL);
      repeat (4) step(8'd0, 8'd0, 8'd0, C_NONE, 8'd64, 8'd32, 8'd64, M_ALL);

      // phase_rst during blank (blank ignores y/cb/cr); next sample sits at phase 0
      step(8'd200, 8'd50, 8'hE2, C_PR | C_BLANK, 8'd64, 8'd32, 8'd64, M_ALL);
      repeat (2) begin
         step(8'd0, 8'd100, 8'd0, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
         step(8'd0, 8'd100, 8'd0, C_NONE, 8'd113, 8'd81, 8'd113, M_ALL);
         step(8'd0, 8'd100, 8'd0, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
         step(8'd0, 8'd100, 8'd0, C_NONE, 8'd14,  8'd0,  8'd14,  M_ALL);
      end

      // V component before and after a line_start pulse
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd113, 8'd81, 8'd113, M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd14,  8'd0,  8'd14,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_LS,   8'd113, 8'd81, 8'd113, M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd113, 8'd81, 8'd14,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd14,  8'd0,  8'd113, M_ALL);

      // burst (PAL: -U and switched V; NTSC: -U only); last one also has blank
      step(8'd99, 8'd33, 8'hB3, C_BURST,           8'd54, 8'd22, 8'd54, M_ALL);
      step(8'd99, 8'd33, 8'hB3, C_BURST,           8'd73, 8'd41, 8'd64, M_ALL);
      step(8'd99, 8'd33, 8'hB3, C_BURST,           8'd73, 8'd41, 8'd73, M_ALL);
      step(8'd99, 8'd33, 8'hB3, C_BURST | C_BLANK, 8'd54, 8'd22, 8'd64, M_ALL);

      // sync priority, then blank only
      step(8'd255, 8'd0,   8'd0,   C_SYNC | C_BURST | C_BLANK, 8'd0, 8'd0, 8'd0, M_ALL);
      step(8'd255, 8'd127, 8'd0,   C_SYNC,  8'd0,  8'd0,  8'd0,  M_ALL);
      step(8'd255, 8'h80,  8'd127, C_BLANK, 8'd64, 8'd32, 8'd64, M_ALL);

      // luma plus chroma, high and low clamping, exact negation of -128
      step(8'd255, 8'd127, 8'd0,  C_NONE, 8'd223, 8'd191, 8'd223, M_ALL);
      step(8'd255, 8'd127, 8'd0,  C_NONE, 8'd255, 8'd254, 8'd255, M_ALL);
      step(8'd0,   8'h80,  8'd0,  C_NONE, 8'd64,  8'd32,  8'd64,  M_ALL);
      step(8'd0,   8'h80,  8'd0,  C_NONE, 8'd127, 8'd95,  8'd127, M_ALL);
      step(8'd0,   8'd0,   8'd0,  C_NONE, 8'd64,  8'd32,  8'd64,  M_ALL);
      step(8'd0,   8'h80,  8'd0,  C_NONE, 8'd0,   8'd0,   8'd0,   M_ALL);
      step(8'd0,   8'd0,   8'h80, C_NONE, 8'd0,   8'd0,   8'd127, M_ALL);

      // active video, then reset mid-line flushes everything in flight
      repeat (4) step(8'd200, 8'd0, 8'd0, C_NONE, 8'd189, 8'd157, 8'd189, M_ALL);
      repeat (4) step(8'd200, 8'd0, 8'd0, C_NONE, 8'd0,   8'd0,   8'd0,   M_ALL);
      step(8'd200, 8'd0, 8'd0, C_RST, 8'd0, 8'd0, 8'd0, M_ALL);

      // after reset: phase restarts at 0 and V-switch is cleared
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd113, 8'd81, 8'd113, M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd14,  8'd0,  8'd14,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      repeat (4) step(8'd200, 8'd0, 8'd0, C_NONE, 8'd189, 8'd157, 8'd189, M_ALL);

      // line_start and phase_rst together
      step(8'd0, 8'd0, 8'd100, C_LS | C_PR | C_BLANK, 8'd64, 8'd32, 8'd64, M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd14,  8'd0,  8'd113, M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd113, 8'd81, 8'd14,  M_ALL);
      step(8'd0, 8'd0, 8'd100, C_NONE, 8'd64,  8'd32, 8'd64,  M_ALL);

      repeat (2) step(8'd0, 8'd0, 8'd0, C_NONE, 8'd0, 8'd0, 8'd0, M_NONE);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d outputs still pending, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
